// File: rtl/executor_move_multi.sv
// Multi-step move executor: applies a direction/step-count command as a series of
// gated unit moves handed to the canvas manager. Option: EXECUTOR_MOVE_TIMEOUT_EN.
package executor_move_multi_pkg;
    typedef enum logic [1:0] {eNonDir, eDown, eLeft, eRight} direction_e;
endpackage

module executor_move_multi
    import executor_move_multi_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int height_p    = 32,
    parameter int max_steps_p = 32,
    parameter int timeout_p   = 64,
    localparam int XW = $clog2(width_p) + 1,
    localparam int YW = $clog2(height_p) + 1,
    localparam int SW = $clog2(max_steps_p) + 1,
    localparam int PW = XW + YW
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          v_i,
    input  direction_e    direction_i,
    input  logic [SW-1:0] steps_i,
    input  logic          abort_i,
    input  logic [PW-1:0] pos_i,          // {y, x}
    input  logic [2:0]    move_avail_i,
    input  logic          cm_is_ready_i,
    output logic [PW-1:0] new_pos_o,      // {y, x}
    output logic          new_pos_v_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          blocked_o,
    output logic [SW-1:0] steps_done_o
`ifdef EXECUTOR_MOVE_TIMEOUT_EN
    ,
    output logic          timeout_o
`endif
);

    typedef enum logic [2:0] {eIDLE, eCheck, eWrite, eWait, eDone} state_e;

    state_e        state_q, state_n;
    direction_e    dir_q;
    logic [SW-1:0] req_q;
    logic [SW-1:0] cnt_q;
    logic          abort_q;
    logic          blocked_q;
    logic          avail_sel;
    logic          abort_now;
    logic [XW-1:0] x_cur, x_nxt;
    logic [YW-1:0] y_cur, y_nxt;
    logic [SW-1:0] req_clamped;

    assign x_cur       = new_pos_o[XW-1:0];
    assign y_cur       = new_pos_o[PW-1:XW];
    assign abort_now   = abort_i | abort_q;
    assign busy_o      = (state_q != eIDLE);
    assign new_pos_v_o = (state_q == eWrite);
    assign req_clamped = (steps_i > SW'(max_steps_p)) ? SW'(max_steps_p) : steps_i;

`ifdef EXECUTOR_MOVE_TIMEOUT_EN
    localparam int TW = $clog2(timeout_p) + 1;
    logic [TW-1:0] wd_cnt_q;
    logic          wd_expire;
    logic          timed_out_q;

    assign wd_expire = (wd_cnt_q == TW'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt_q    <= '0;
            timed_out_q <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= (state_q == eDone) && timed_out_q;
            if (state_q == eIDLE && v_i) begin
                timed_out_q <= 1'b0;
            end
            if (state_q == eWrite) begin
                wd_cnt_q <= '0;
            end else if (state_q == eWait && !cm_is_ready_i) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
                if (wd_expire) begin
                    timed_out_q <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_p;
`endif

    always_comb begin
        avail_sel = 1'b0;
        x_nxt     = x_cur;
        y_nxt     = y_cur;
        case (dir_q)
            eDown: begin
                avail_sel = move_avail_i[2];
                y_nxt     = y_cur + 1'b1;
            end
            eLeft: begin
                avail_sel = move_avail_i[0];
                x_nxt     = x_cur - 1'b1;
            end
            eRight: begin
                avail_sel = move_avail_i[1];
                x_nxt     = x_cur + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            eIDLE: begin
                if (v_i) begin
                    state_n = (direction_i == eNonDir || steps_i == '0) ? eDone : eCheck;
                end
            end
            eCheck: begin
                if (abort_now || !avail_sel) state_n = eDone;
                else                         state_n = eWrite;
            end
            eWrite: state_n = eWait;
            eWait: begin
                if (cm_is_ready_i) begin
                    state_n = (cnt_q == req_q) ? eDone : eCheck;
                end
`ifdef EXECUTOR_MOVE_TIMEOUT_EN
                else if (wd_expire) begin
                    state_n = eDone;
                end
`endif
            end
            eDone:   state_n = eIDLE;
            default: state_n = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= eIDLE;
            new_pos_o    <= '0;
            dir_q        <= eNonDir;
            req_q        <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            blocked_q    <= 1'b0;
            done_o       <= 1'b0;
            blocked_o    <= 1'b0;
            steps_done_o <= '0;
        end else begin
            state_q   <= state_n;
            done_o    <= (state_q == eDone);
            blocked_o <= (state_q == eDone) && blocked_q;
            case (state_q)
                eIDLE: begin
                    if (v_i) begin
                        new_pos_o <= pos_i;
                        dir_q     <= direction_i;
                        req_q     <= req_clamped;
                        cnt_q     <= '0;
                        abort_q   <= 1'b0;
                        blocked_q <= 1'b0;
                    end
                end
                eCheck: begin
                    // abort takes precedence over an unavailable move
                    blocked_q <= !abort_now && !avail_sel;
                    if (!abort_now && avail_sel) begin
                        new_pos_o <= {y_nxt, x_nxt};
                    end
                end
                eWrite: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (abort_i) abort_q <= 1'b1;
                end
                eWait: begin
                    if (abort_i) abort_q <= 1'b1;
                end
                eDone: begin
                    steps_done_o <= cnt_q;
                end
                default: ;
            endcase
        end
    end

endmodule
